// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per clock.
// Quotient goes to LO and remainder to HI. A start/done handshake lets control stall while busy.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
  logic [WIDTH-1:0] quot_q, rout_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q, r_neg_q, dz_q;

  logic             accept, s1, s2, last, fit;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nx, dvd_nx;
  logic [WIDTH:0]   trial, diff;

  assign s1     = signed_i & src1_i[WIDTH-1];
  assign s2     = signed_i & src2_i[WIDTH-1];
  assign a_mag  = s1 ? -src1_i : src1_i;
  assign b_mag  = s2 ? -src2_i : src2_i;
  assign accept = start_i && (state_q != RUN);
  assign last   = (cnt_q == CW'(1));

  // Partial remainder stays below the divisor, so WIDTH+1 bits
  // hold the shifted trial value without overflow.
  always_comb begin
    trial  = {rem_q, dvd_q[WIDTH-1]};
    diff   = trial - {1'b0, dsr_q};
    fit    = ~diff[WIDTH];
    rem_nx = fit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_nx = {dvd_q[WIDTH-2:0], fit};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i)
          state_d = (src2_i == '0) ? DONE : RUN;
        else
          state_d = IDLE;
      end
      RUN: begin
        if (last)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rout_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q   <= '0;
        dvd_q   <= a_mag;
        dsr_q   <= b_mag;
        cnt_q   <= CW'(WIDTH);
        q_neg_q <= s1 ^ s2;
        r_neg_q <= s1;
        // Divide by zero bypasses the iteration and the sign fixup
        if (src2_i == '0) begin
          quot_q <= '1;
          rout_q <= src1_i;
          dz_q   <= 1'b1;
        end
      end else if (state_q == RUN) begin
        rem_q <= rem_nx;
        dvd_q <= dvd_nx;
        cnt_q <= cnt_q - CW'(1);
        if (last) begin
          quot_q <= q_neg_q ? -dvd_nx : dvd_nx;
          rout_q <= r_neg_q ? -rem_nx : rem_nx;
          dz_q   <= 1'b0;
        end
      end
    end
  end

  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign quot_o     = quot_q;
  assign rem_o      = rout_q;
  assign div_zero_o = dz_q;

endmodule
